// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the MiniUart receive controller: bus register map,
// STATUS bit layout, drain FSM encoding and the STATUS packing helper.
package uart_rx_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int STAT_OVERRUN = 15;
  localparam int STAT_FULL    = 14;
  localparam int STAT_EMPTY   = 13;
  localparam int STAT_TIMEOUT = 12;

  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_CLR_OVR = 1;

  typedef enum logic [1:0] {
    DRAIN_IDLE = 2'd0,
    DRAIN_CAPT = 2'd1,
    DRAIN_WCLR = 2'd2
  } drain_state_e;

  function automatic logic [31:0] pack_status(input logic overrun, input logic full,
                                              input logic empty, input logic timeout,
                                              input logic [7:0] count);
    logic [31:0] w;
    w = 32'd0;
    w[STAT_OVERRUN] = overrun;
    w[STAT_FULL]    = full;
    w[STAT_EMPTY]   = empty;
    w[STAT_TIMEOUT] = timeout;
    w[7:0]          = count;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// uart_rx_fifo: synchronous byte FIFO. A push into a full FIFO is accepted only
// when a pop happens on the same edge; pointers wrap modulo DEPTH (power of 2).
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  output logic [7:0]    data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push_s, do_pop_s;

  assign empty_o   = (count_q == CNT_ZERO);
  assign full_o    = (count_q == DEPTH_C);
  assign count_o   = count_q;
  assign data_o    = mem_q[rd_ptr_q];
  assign do_pop_s  = pop_i & ~empty_o;
  assign do_push_s = push_i & (~full_o | do_pop_s);

  // Storage has no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: baud tick generator, receive drain FSM, byte FIFO and CPU register file.
// Optional receive-idle timeout interrupt is built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter int          AW        = 4,
  parameter logic [15:0] DIV_RST   = 16'd26,
  parameter int          RX_THRESH = 1,
  parameter int          TO_TICKS  = 320
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rx_en,
  input  logic        rx_rs,
  input  logic [7:0]  rx_data,
  output logic        rx_over_read,
  input  logic [1:0]  bus_addr,
  input  logic        bus_rd,
  input  logic        bus_wr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        irq
);

  localparam logic [AW:0] THRESH_C = (AW+1)'(RX_THRESH);

  logic [15:0]  div_q, cnt_q;
  logic         rx_en_q, rs_q, overrun_q, irq_en_q, irq_q, timeout_s;
  drain_state_e state_q, state_d;
  logic [7:0]   head_s;
  logic         full_s, empty_s;
  logic [AW:0]  count_s;
  logic         div_wr_s, ctrl_wr_s, data_rd_s, capt_s, pop_s, push_done_s;
  logic         unused_wdata_s;

  assign div_wr_s       = bus_wr & (bus_addr == ADDR_DIV);
  assign ctrl_wr_s      = bus_wr & (bus_addr == ADDR_CTRL);
  assign data_rd_s      = bus_rd & (bus_addr == ADDR_DATA);
  assign capt_s         = (state_q == DRAIN_CAPT);
  assign pop_s          = data_rd_s & ~empty_s;
  assign push_done_s    = capt_s & (~full_s | pop_s);
  assign unused_wdata_s = ^bus_wdata[31:16];

  assign rx_en        = rx_en_q;
  assign rx_over_read = capt_s;
  assign irq          = irq_q;

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (capt_s),
    .data_i  (rx_data),
    .pop_i   (pop_s),
    .data_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

  // Divisor register and baud tick counter; a divisor write restarts the period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= DIV_RST;
      cnt_q   <= 16'd0;
      rx_en_q <= 1'b0;
    end else if (div_wr_s) begin
      div_q   <= bus_wdata[15:0];
      cnt_q   <= 16'd0;
      rx_en_q <= 1'b0;
    end else if (cnt_q == div_q) begin
      cnt_q   <= 16'd0;
      rx_en_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_q + 16'd1;
      rx_en_q <= 1'b0;
    end
  end

  // Drain FSM state and the registered receiver status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_q    <= 1'b0;
      state_q <= DRAIN_IDLE;
    end else begin
      rs_q    <= rx_rs;
      state_q <= state_d;
    end
  end

  // Waiting in WCLR for status to drop guarantees one capture per byte.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DRAIN_IDLE: if (rs_q) state_d = DRAIN_CAPT; else state_d = DRAIN_IDLE;
      DRAIN_CAPT: state_d = DRAIN_WCLR;
      DRAIN_WCLR: if (!rs_q) state_d = DRAIN_IDLE; else state_d = DRAIN_WCLR;
      default:    state_d = DRAIN_IDLE;
    endcase
  end

  // Control bits and sticky overrun; a clear request beats a same-edge drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (ctrl_wr_s) irq_en_q <= bus_wdata[CTRL_IRQ_EN];
      if (ctrl_wr_s && bus_wdata[CTRL_CLR_OVR]) overrun_q <= 1'b0;
      else if (capt_s && !push_done_s)          overrun_q <= 1'b1;
    end
  end

  // Level interrupt, registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_en_q & ((count_s >= THRESH_C) | overrun_q | timeout_s);
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam logic [15:0] TO_C = 16'(TO_TICKS);
  logic [15:0] idle_q;
  logic        timeout_q;
  logic        activity_s;

  assign activity_s = push_done_s | pop_s;
  assign timeout_s  = timeout_q;

  // Idle tick counter saturates at the threshold; timeout holds until FIFO traffic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q    <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      if (activity_s || empty_s)            idle_q <= 16'd0;
      else if (rx_en_q && (idle_q != TO_C)) idle_q <= idle_q + 16'd1;
      if (activity_s)           timeout_q <= 1'b0;
      else if (idle_q == TO_C)  timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Combinational register read mux; an empty FIFO reads as zero.
  always_comb begin
    bus_rdata = 32'd0;
    case (bus_addr)
      ADDR_DATA:   if (!empty_s) bus_rdata = {24'd0, head_s}; else bus_rdata = 32'd0;
      ADDR_STATUS: bus_rdata = pack_status(overrun_q, full_s, empty_s, timeout_s, 8'(count_s));
      ADDR_DIV:    bus_rdata = {16'd0, div_q};
      ADDR_CTRL:   bus_rdata = {31'd0, irq_en_q};
      default:     bus_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: randomized bytes against a queue-based
// reference of the FIFO, overrun flag and interrupt level.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 16;
`ifdef UART_RX_TIMEOUT_EN
  localparam int TH = 4;
`else
  localparam int TH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_en;
  logic        rx_rs = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_over_read;
  logic [1:0]  bus_addr = 2'd0;
  logic        bus_rd = 1'b0;
  logic        bus_wr = 1'b0;
  logic [31:0] bus_wdata = 32'd0;
  logic [31:0] bus_rdata;
  logic        irq;

  int total = 0;
  int bad = 0;
  int or_cnt = 0;
  logic [7:0] mq[$];
  bit movr = 1'b0;
  bit mien = 1'b0;

  uart_rx_ctrl #(.DEPTH(DEPTH), .AW(4), .DIV_RST(16'd26), .RX_THRESH(TH), .TO_TICKS(320)) dut (
    .clk(clk), .rst(rst), .rx_en(rx_en), .rx_rs(rx_rs), .rx_data(rx_data),
    .rx_over_read(rx_over_read), .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_over_read === 1'b1) or_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] exp_status(input int n, input bit ovr, input bit to);
    logic [31:0] w;
    w = 32'(n);
    if (ovr) w = w + 32'h8000;
    if (n == DEPTH) w = w + 32'h4000;
    if (n == 0) w = w + 32'h2000;
    if (to) w = w + 32'h1000;
    return w;
  endfunction

  function automatic logic exp_irq();
    return mien && ((mq.size() >= TH) || movr);
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); bus_addr = a; bus_wdata = d; bus_wr = 1'b1;
    @(negedge clk); bus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk); bus_addr = a; bus_rd = 1'b1;
    #1 d = bus_rdata;
    @(negedge clk); bus_rd = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    int start;
    bit seen;
    start = or_cnt;
    seen = 1'b0;
    @(negedge clk); rx_data = b; rx_rs = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rx_over_read === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL send_wait: got no over_read, need one for byte %02h", b); end
    repeat (hold) @(negedge clk);
    rx_rs = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (or_cnt - start !== 1) begin
      bad++; $display("FAIL over_read_pulses: got %0d need 1", or_cnt - start);
    end
    if (mq.size() < DEPTH) mq.push_back(b); else movr = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({rx_en, rx_over_read, irq} !== 3'b000) begin
      bad++; $display("FAIL reset_outputs: got %b need 000", {rx_en, rx_over_read, irq});
    end
    bus_addr = 2'd1; #1;
    total++;
    if (bus_rdata !== 32'h2000) begin bad++; $display("FAIL reset_status: got %h need 00002000", bus_rdata); end
    bus_addr = 2'd2; #1;
    total++;
    if (bus_rdata !== 32'd26) begin bad++; $display("FAIL reset_div: got %0d need 26", bus_rdata); end
    bus_addr = 2'd3; #1;
    total++;
    if (bus_rdata !== 32'd0) begin bad++; $display("FAIL reset_ctrl: got %h need 0", bus_rdata); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_tick();
    int p;
    int first;
    bit s[24];
    logic [31:0] d;
    for (int t = 0; t < 2; t++) begin
      p = (t == 0) ? 4 : int'($urandom_range(2, 7));
      bus_write(2'd2, 32'(p - 1));
      for (int i = 0; i < 24; i++) begin @(negedge clk); s[i] = rx_en; end
      first = -1;
      for (int i = 0; i < 24; i++) if (s[i] && first < 0) first = i;
      total++;
      if (first < 0 || first >= p) begin bad++; $display("FAIL tick_first: got %0d need 0..%0d", first, p - 1); end
      else begin
        for (int i = first; i < 24; i++) begin
          total++;
          if (s[i] !== (((i - first) % p) == 0)) begin
            bad++; $display("FAIL tick_period%0d: sample %0d got %b", p, i, s[i]);
          end
        end
      end
    end
    bus_write(2'd2, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (rx_en !== 1'b1) begin bad++; $display("FAIL tick_div0: got %b need 1", rx_en); end
    end
    bus_read(2'd2, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL div_readback: got %h need 0", d); end
    bus_write(2'd2, 32'd26);
  endtask

  task automatic test_single_byte();
    logic [31:0] d;
    send_byte(8'hA5, 0);
    bus_read(2'd1, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL single_status: got %h need 00000001", d); end
    bus_read(2'd0, d);
    void'(mq.pop_front());
    total++;
    if (d !== 32'hA5) begin bad++; $display("FAIL single_data: got %h need 000000a5", d); end
    bus_read(2'd1, d);
    total++;
    if (d !== 32'h2000) begin bad++; $display("FAIL single_empty: got %h need 00002000", d); end
    bus_read(2'd0, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL empty_read: got %h need 0", d); end
  endtask

  task automatic test_hold();
    logic [7:0] b;
    logic [31:0] d;
    b = 8'($urandom);
    send_byte(b, 10);
    bus_read(2'd1, d);
    total++;
    if (d !== exp_status(1, 1'b0, 1'b0)) begin bad++; $display("FAIL hold_status: got %h need 00000001", d); end
    bus_read(2'd0, d);
    total++;
    if (d !== {24'd0, mq.pop_front()}) begin bad++; $display("FAIL hold_data: got %h need %h", d, b); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    for (int i = 0; i < 17; i++) send_byte(8'($urandom), 0);
    bus_read(2'd1, d);
    total++;
    if (d !== 32'hC010) begin bad++; $display("FAIL ovf_status: got %h need 0000c010", d); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL ovf_irq_masked: got %b need 0", irq); end
    for (int i = 0; i < 16; i++) begin
      bus_read(2'd0, d);
      total++;
      if (d !== {24'd0, mq[0]}) begin bad++; $display("FAIL ovf_order%0d: got %h need %h", i, d, mq[0]); end
      void'(mq.pop_front());
    end
    bus_read(2'd1, d);
    total++;
    if (d !== 32'hA000) begin bad++; $display("FAIL ovf_drained: got %h need 0000a000", d); end
    bus_write(2'd3, 32'h2);
    movr = 1'b0;
    bus_read(2'd1, d);
    total++;
    if (d !== 32'h2000) begin bad++; $display("FAIL ovr_clear: got %h need 00002000", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    bus_write(2'd3, 32'h1);
    mien = 1'b1;
    for (int i = 0; i < TH; i++) send_byte(8'($urandom), 0);
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_thresh: got %b need 1", irq); end
    while (mq.size() > 0) begin bus_read(2'd0, d); void'(mq.pop_front()); end
    repeat (2) @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_empty: got %b need 0", irq); end
    for (int i = 0; i < 17; i++) send_byte(8'($urandom), 0);
    while (mq.size() > 0) begin bus_read(2'd0, d); void'(mq.pop_front()); end
    repeat (2) @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_overrun: got %b need 1", irq); end
    bus_write(2'd3, 32'h3);
    movr = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_ovr_clear: got %b need 0", irq); end
  endtask

  task automatic test_same_cycle();
    logic [7:0] nb;
    logic [31:0] d;
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
    nb = 8'($urandom);
    @(negedge clk); rx_data = nb; rx_rs = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (rx_over_read !== 1'b1) begin bad++; $display("FAIL same_capt: got over_read %b need 1", rx_over_read); end
    bus_addr = 2'd0; bus_rd = 1'b1;
    #1 d = bus_rdata;
    total++;
    if (d !== {24'd0, mq[0]}) begin bad++; $display("FAIL same_head: got %h need %h", d, mq[0]); end
    @(negedge clk); bus_rd = 1'b0; rx_rs = 1'b0;
    void'(mq.pop_front());
    mq.push_back(nb);
    repeat (3) @(negedge clk);
    bus_read(2'd1, d);
    total++;
    if (d !== exp_status(3, 1'b0, 1'b0)) begin bad++; $display("FAIL same_count: got %h need 00000003", d); end
    for (int i = 0; i < 3; i++) begin
      bus_read(2'd0, d);
      total++;
      if (d !== {24'd0, mq[0]}) begin bad++; $display("FAIL same_order%0d: got %h need %h", i, d, mq[0]); end
      void'(mq.pop_front());
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [31:0] want;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        send_byte(8'($urandom), int'($urandom_range(0, 3)));
      end else begin
        want = (mq.size() > 0) ? {24'd0, mq[0]} : 32'd0;
        bus_read(2'd0, d);
        if (mq.size() > 0) void'(mq.pop_front());
        total++;
        if (d !== want) begin bad++; $display("FAIL rand_data%0d: got %h need %h", it, d, want); end
      end
      @(negedge clk);
      total++;
      if (irq !== exp_irq()) begin bad++; $display("FAIL rand_irq%0d: got %b need %b", it, irq, exp_irq()); end
      if (it % 6 == 5) begin
        bus_read(2'd1, d);
        total++;
        if (d !== exp_status(mq.size(), movr, 1'b0)) begin
          bad++; $display("FAIL rand_status%0d: got %h need %h", it, d, exp_status(mq.size(), movr, 1'b0));
        end
      end
    end
    while (mq.size() > 0) begin bus_read(2'd0, d); void'(mq.pop_front()); end
    bus_write(2'd3, 32'h3);
    movr = 1'b0;
    bus_read(2'd1, d);
    total++;
    if (d !== 32'h2000) begin bad++; $display("FAIL rand_final: got %h need 00002000", d); end
  endtask

`ifdef UART_RX_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] d;
    bus_write(2'd2, 32'd0);
    send_byte(8'($urandom), 0);
    repeat (250) @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL to_early: got %b need 0", irq); end
    repeat (100) @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL to_fire: got %b need 1", irq); end
    bus_read(2'd1, d);
    total++;
    if (d !== exp_status(1, 1'b0, 1'b1)) begin bad++; $display("FAIL to_status: got %h need 00001001", d); end
    bus_read(2'd0, d);
    void'(mq.pop_front());
    repeat (2) @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL to_clear: got %b need 0", irq); end
    bus_write(2'd2, 32'd26);
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [7:0] b;
    send_byte(8'($urandom), 0);
    send_byte(8'($urandom), 0);
    @(negedge clk); rx_data = 8'h3C; rx_rs = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (rx_over_read !== 1'b1) begin bad++; $display("FAIL mid_capt: got over_read %b need 1", rx_over_read); end
    rst = 1'b1;
    bus_addr = 2'd1;
    #1;
    total++;
    if ({rx_en, rx_over_read, irq} !== 3'b000) begin
      bad++; $display("FAIL mid_outputs: got %b need 000", {rx_en, rx_over_read, irq});
    end
    total++;
    if (bus_rdata !== 32'h2000) begin bad++; $display("FAIL mid_status: got %h need 00002000", bus_rdata); end
    mq.delete();
    movr = 1'b0;
    mien = 1'b0;
    @(negedge clk); rx_rs = 1'b0;
    @(negedge clk); rst = 1'b0;
    b = 8'($urandom);
    send_byte(b, 0);
    bus_read(2'd0, d);
    void'(mq.pop_front());
    total++;
    if (d !== {24'd0, b}) begin bad++; $display("FAIL mid_resume: got %h need %h", d, b); end
  endtask

  initial begin
    test_reset();
    test_tick();
    test_single_byte();
    test_hold();
    test_overflow();
    test_irq();
    test_same_cycle();
    test_random();
`ifdef UART_RX_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
